// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control and status bundle between a controller and the down-counter timer.
interface down_counter_timer_if #(parameter int WIDTH = 8);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             zero;
    modport master (output load, load_val, start, pause, stop, input count, busy, done, zero);
    modport slave  (input load, load_val, start, pause, stop, output count, busy, done, zero);
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable, pausable down-counter with a one-cycle done pulse at terminal count.
// Define DOWN_COUNTER_TIMER_AUTORELOAD_EN to reload from the last loaded value and keep running.
module down_counter_timer #(parameter int WIDTH = 8) (
    input  logic clk,
    input  logic RST,
    down_counter_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
    state_t state;
    logic [WIDTH-1:0] eff;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
`endif
    // A start in IDLE sees the value being loaded on the same edge.
    assign eff = bus.load ? bus.load_val : bus.count;
    assign bus.zero = bus.count == '0;
    always_ff @(posedge clk) begin
        bus.done <= 1'b0;
        if (RST) begin
            state <= IDLE;
            bus.count <= '0;
            bus.busy <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload <= '0;
`endif
        end else if (bus.stop) begin
            state <= IDLE;
            bus.busy <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.load) begin
                bus.count <= bus.load_val;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
                reload <= bus.load_val;
`endif
            end
            if (bus.start && eff != '0) begin
                state <= RUN;
                bus.busy <= 1'b1;
            end else if (bus.start) begin
                bus.done <= 1'b1;
            end
        end else if (bus.load) begin
            bus.count <= bus.load_val;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload <= bus.load_val;
`endif
            if (bus.load_val == '0) begin
                state <= IDLE;
                bus.busy <= 1'b0;
            end
        end else if (state == PAUSED) begin
            if (!bus.pause) state <= RUN;
        end else if (bus.pause) begin
            state <= PAUSED;
        end else if (bus.count == WIDTH'(1)) begin
            bus.done <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            bus.count <= reload;
            if (reload == '0) begin
                state <= IDLE;
                bus.busy <= 1'b0;
            end
`else
            bus.count <= '0;
            state <= IDLE;
            bus.busy <= 1'b0;
`endif
        end else begin
            bus.count <= bus.count - WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed stimulus, per-cycle check against a behavioural model plus literal pins.
module tb_down_counter_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;
    logic [7:0] m_cnt = '0;
    logic [7:0] m_rel = '0;
    logic m_active = 1'b0;
    logic m_frozen = 1'b0;
    logic m_done = 1'b0;

    down_counter_timer_if #(.WIDTH(8)) bus();
    down_counter_timer #(.WIDTH(8)) dut (.clk(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a timer that is either idle, running or frozen, counting remaining ticks.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_cnt = '0; m_rel = '0; m_active = 1'b0; m_frozen = 1'b0;
        end else if (bus.stop) begin
            m_active = 1'b0; m_frozen = 1'b0;
        end else if (!m_active) begin
            if (bus.load) begin m_cnt = bus.load_val; m_rel = bus.load_val; end
            if (bus.start) begin
                if (m_cnt != 0) m_active = 1'b1;
                else m_done = 1'b1;
            end
        end else if (bus.load) begin
            m_cnt = bus.load_val; m_rel = bus.load_val;
            if (bus.load_val == 0) begin m_active = 1'b0; m_frozen = 1'b0; end
        end else if (m_frozen) begin
            if (!bus.pause) m_frozen = 1'b0;
        end else if (bus.pause) begin
            m_frozen = 1'b1;
        end else begin
            m_cnt = m_cnt - 8'd1;
            if (m_cnt == 0) begin
                m_done = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
                if (m_rel != 0) m_cnt = m_rel;
                else m_active = 1'b0;
`else
                m_active = 1'b0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_count", bus.count, m_cnt);
            chk("cyc_busy", bus.busy, m_active);
            chk("cyc_done", bus.done, m_done);
            chk("cyc_zero", bus.zero, m_cnt == 0);
        end
    end

    task automatic drive(input logic l, input logic [7:0] lv, input logic s, input logic p, input logic sp);
        bus.load = l; bus.load_val = lv; bus.start = s; bus.pause = p; bus.stop = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin(input string name, input logic [7:0] c, input logic b, input logic d);
        chk({name, "_count"}, bus.count, c);
        chk({name, "_busy"}, bus.busy, b);
        chk({name, "_done"}, bus.done, d);
        chk({name, "_model"}, {m_cnt, m_active, m_done}, {c, b, d});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        pin("reset", 8'd0, 1'b0, 1'b0);
        chk("reset_zero", bus.zero, 1);
        rst = 1'b0;
        chk_en = 1'b1;

        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        pin("basic_e0", 8'd5, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            idle();
            pin("basic_run", 8'(5 - k), k != 5, k == 5);
        end
        idle();
        pin("basic_after", 8'd0, 1'b0, 1'b0);

        drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        pin("pause_pre", 8'd2, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
            pin("pause_hold", 8'd2, 1'b1, 1'b0);
        end
        idle();
        pin("pause_resume", 8'd2, 1'b1, 1'b0);
        idle();
        pin("pause_e7", 8'd1, 1'b1, 1'b0);
        idle();
        pin("pause_e8", 8'd0, 1'b0, 1'b1);

        drive(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        pin("ldstart_e0", 8'd3, 1'b1, 1'b0);
        idle();
        idle();
        idle();
        pin("ldstart_e3", 8'd0, 1'b0, 1'b1);

        drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        drive(1'b1, 8'd7, 1'b0, 1'b0, 1'b1);
        pin("stop_load", 8'd2, 1'b0, 1'b0);

        drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        pin("zero_start", 8'd0, 1'b0, 1'b1);
        idle();
        pin("zero_after", 8'd0, 1'b0, 1'b0);

        drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        idle();
        pin("rst_pre", 8'd1, 1'b1, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        pin("rst_mid", 8'd0, 1'b0, 1'b0);

        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        idle();
        drive(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
        pin("reload_run", 8'd6, 1'b1, 1'b0);
        idle();
        pin("reload_dec", 8'd5, 1'b1, 1'b0);
        drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        pin("load0_run", 8'd0, 1'b0, 1'b0);

        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
        pin("paused_load", 8'd2, 1'b1, 1'b0);
        drive(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
        pin("paused_load0", 8'd0, 1'b0, 1'b0);

`ifndef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        pin("b2b_done", 8'd0, 1'b0, 1'b1);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        pin("b2b_nold", 8'd0, 1'b0, 1'b1);
        drive(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        pin("b2b_ld", 8'd3, 1'b1, 1'b0);
        idle();
        idle();
        idle();
        pin("b2b_end", 8'd0, 1'b0, 1'b1);
`else
        drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        pin("auto_e0", 8'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            idle();
            pin("auto_run", (k % 3 == 0) ? 8'd3 : 8'(3 - k % 3), 1'b1, k % 3 == 0);
        end
        idle();
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        pin("auto_stop", 8'd2, 1'b0, 1'b0);
`endif
        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
